// File: rtl/alu_mc_if.sv
// Operation launch and result bus between the datapath controller and alu_mc.
// The master drives the operation; the slave (the ALU) returns result and status.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             err_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  result_o, zero_o, err_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output result_o, zero_o, err_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle logic/arith/compare/jr ops, WIDTH-iteration
// shift-add multiply. Result and branch flag are registered with a done pulse.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_mc_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'b1111;
  localparam logic [3:0] OP_BNE = 4'b1000;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH:0]   op_out;

  // Returns {unsupported, result} for every code except multiply.
  function automatic logic [WIDTH:0] single_op(input logic [3:0] ctrl,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH:0]          r;
    sa = a;
    sb = b;
    r  = '0;
    case (ctrl)
      4'b0000: r[WIDTH-1:0] = a & b;
      4'b0001: r[WIDTH-1:0] = a | b;
      4'b0010: r[WIDTH-1:0] = a + b;
      4'b0110: r[WIDTH-1:0] = a - b;
      4'b0111: r[WIDTH-1:0] = (sa < sb) ? WIDTH'(1) : '0;
      4'b1000: r[WIDTH-1:0] = a - b;
      4'b1011: r[WIDTH-1:0] = a;
      default: r[WIDTH]     = 1'b1;
    endcase
    return r;
  endfunction

  // bne inverts the sense so branch logic can always test zero.
  function automatic logic zero_flag(input logic [3:0] ctrl, input logic [WIDTH-1:0] res);
    return (ctrl == OP_BNE) ? (res != '0) : (res == '0);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    op_out   = single_op(bus.ctrl_i, bus.src1_i, bus.src2_i);
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.ctrl_i == OP_MUL) begin
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d = op_out[WIDTH-1:0];
            err_d    = op_out[WIDTH];
            zero_d   = op_out[WIDTH] ? 1'b0 : zero_flag(bus.ctrl_i, op_out[WIDTH-1:0]);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        // Fixed-length sequence; start_i is deliberately not looked at here.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.err_o    = err_q;
  assign bus.done_o   = done_q;
  assign bus.busy_o   = (state_q == MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: operation semantics from plain arithmetic.
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic z, output logic e);
    e = 1'b0;
    case (c)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = a + b;
      4'd6:  res = a - b;
      4'd7:  res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  res = a - b;
      4'd11: res = a;
      4'd15: res = W'(64'(a) * 64'(b));
      default: begin res = '0; e = 1'b1; end
    endcase
    if (e) z = 1'b0;
    else if (c == 4'd8) z = (res != 0);
    else z = (res == 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er, prev;
    logic ez, ee;
    int lat, busy_n;
    bit held;
    model(c, a, b, er, ez, ee);
    prev = bus.result_o;
    bus.start_i = 1'b1; bus.ctrl_i = c; bus.src1_i = a; bus.src2_i = b;
    tick();
    bus.start_i = 1'b0;
    lat = 1; busy_n = 0; held = 1'b1;
    while (!bus.done_o && lat < 100) begin
      if (bus.busy_o) busy_n++;
      if (bus.result_o !== prev) held = 1'b0;
      tick();
      lat++;
    end
    chk("latency", lat, (c == 4'd15) ? 33 : 1);
    chk("busy_cycles", busy_n, (c == 4'd15) ? 32 : 0);
    chk("result", bus.result_o, er);
    chk("zero", bus.zero_o, ez);
    chk("err", bus.err_o, ee);
    chk("busy_at_done", bus.busy_o, 0);
    if (c == 4'd15) chk("held_during_mul", held, 1);
    tick();
    chk("done_err_pulse", {bus.done_o, bus.err_o}, 0);
    chk("result_hold", bus.result_o, er);
  endtask

  initial begin
    logic [W-1:0] er, res_seen, a, b;
    logic ez, ee;
    logic [3:0] c;
    int dones, done_k;
    bit quiet;

    bus.start_i = 1'b0; bus.ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("reset_idle", {bus.result_o, bus.zero_o, bus.err_o, bus.busy_o, bus.done_o}, 0);
      tick();
    end

    run_op(4'd2, 5, 7);
    chk("add_5_7", {bus.result_o, bus.zero_o}, {32'd12, 1'b0});
    run_op(4'd6, 7, 7);
    chk("sub_7_7", {bus.result_o, bus.zero_o}, {32'd0, 1'b1});
    run_op(4'd7, 32'hFFFFFFFF, 1);
    chk("slt_m1_1", bus.result_o, 1);
    run_op(4'd8, 4, 4);
    chk("bne_4_4", {bus.result_o, bus.zero_o}, {32'd0, 1'b0});
    run_op(4'd11, 32'h00400020, 0);
    chk("jr", bus.result_o, 32'h00400020);
    run_op(4'd15, 32'h0000FFFF, 32'h00010001);
    chk("mul_ffff", bus.result_o, 32'hFFFFFFFF);
    run_op(4'd15, 32'hFFFFFFFD, 7);
    chk("mul_neg3_7", bus.result_o, 32'hFFFFFFEB);
    run_op(4'd5, 32'h12345678, 32'h1);
    chk("illegal_0101", {bus.result_o, bus.zero_o}, {32'd0, 1'b0});

    // Back-to-back single-cycle ops, one start per cycle.
    c = 4'd0; a = 0; b = 0;
    for (int i = 0; i < 12; i++) begin
      do c = 4'($urandom_range(0, 15)); while (c == 4'd15);
      a = $urandom; b = (i % 3 == 0) ? a : $urandom;
      bus.start_i = 1'b1; bus.ctrl_i = c; bus.src1_i = a; bus.src2_i = b;
      tick();
      model(c, a, b, er, ez, ee);
      chk("b2b_done", bus.done_o, 1);
      chk("b2b_result", {bus.result_o, bus.zero_o, bus.err_o}, {er, ez, ee});
    end
    bus.start_i = 1'b0;
    tick();

    // Start during busy is ignored.
    model(4'd15, 32'h00001234, 32'h00000567, er, ez, ee);
    bus.start_i = 1'b1; bus.ctrl_i = 4'd15; bus.src1_i = 32'h00001234; bus.src2_i = 32'h00000567;
    tick();
    bus.start_i = 1'b0;
    dones = 0; done_k = 0; res_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done_o) begin dones++; done_k = k; res_seen = bus.result_o; end
      if (k == 10) begin
        bus.start_i = 1'b1; bus.ctrl_i = 4'd2; bus.src1_i = 1; bus.src2_i = 1;
      end
      if (k == 11) bus.start_i = 1'b0;
      tick();
    end
    chk("intrude_dones", dones, 1);
    chk("intrude_latency", done_k, 33);
    chk("intrude_result", res_seen, er);

    // Reset at iteration 15 of a multiply.
    bus.start_i = 1'b1; bus.ctrl_i = 4'd15; bus.src1_i = 32'h0000FFFF; bus.src2_i = 32'h00010001;
    tick();
    bus.start_i = 1'b0;
    repeat (14) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_mid_state", {bus.busy_o, bus.done_o, bus.result_o}, 0);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done_o || bus.busy_o) quiet = 1'b0;
      tick();
    end
    chk("rst_mid_no_done", quiet, 1);
    run_op(4'd2, 2, 3);
    chk("after_rst_add", bus.result_o, 5);

    // Randomized ops, all codes including multiply and illegal ones.
    for (int i = 0; i < 30; i++) begin
      c = 4'($urandom_range(0, 15));
      a = (i % 4 == 0) ? W'($urandom_range(0, 15)) : $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      run_op(c, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multicycle ALU that executes the 4-bit operation codes produced by the ALU controller. It accepts one operation per `start_i` pulse, completes logic, add/sub, compare and jump-register pass-through in one cycle, and runs `mul` as a 32-iteration shift-add sequence. The result and branch flag are registered and presented with a one-cycle `done_o` pulse, so the datapath can stall on `busy_o` during multiplies.

## Interface
- `WIDTH`, default 32: operand/result width; multiplier iteration count equals `WIDTH`.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  launch operation; sampled only when `busy_o`=0.
- `ctrl_i`  in  4  operation code, sampled with `start_i`.
- `src1_i`  in  WIDTH  operand A (rs), sampled with `start_i`.
- `src2_i`  in  WIDTH  operand B (rt/immediate), sampled with `start_i`.
- `result_o`  out  WIDTH  registered result, held until next `done_o`.
- `zero_o`  out  1  registered branch flag, updated with `result_o`.
- `err_o`  out  1  one-cycle pulse with `done_o` for an unsupported `ctrl_i`.
- `busy_o`  out  1  high while a multiply is iterating.
- `done_o`  out  1  one-cycle pulse when `result_o`/`zero_o` are newly valid.

## Operation
- Op codes:
  - 0000: and.
  - 0001: or.
  - 0010: add (wraps mod 2^WIDTH, no overflow flag).
  - 0110: sub, A-B wrap.
  - 0111: slt, signed; result 1 or 0.
  - 1000: bne-sub, result A-B.
  - 1011: jr; result = A.
  - 1111: mul; result = low WIDTH bits of A*B, identical for signed and unsigned operands.
- `zero_o` = (result==0) for every op except 1000, where `zero_o` = (result!=0), so branch logic always tests `zero_o`.
- Unsupported code:
  - `result_o`=0, `zero_o`=0, `err_o`=1, single-cycle timing.
- States:
  - IDLE → IDLE on a single-cycle op. The result registers, `done_o` pulses.
  - IDLE → MUL on `start_i` with 1111:
    - Load multiplicand=A, multiplier=B, acc=0, count=0.
  - MUL, each cycle:
    - If multiplier[0], acc += multiplicand.
    - Multiplicand <<= 1, multiplier >>= 1 (logical), count++.
  - MUL exit when count reaches WIDTH-1 in an iteration. Write the final acc to `result_o`, pulse `done_o`, go to IDLE.
  - No early termination: a multiply always takes WIDTH iterations.
- `start_i` while `busy_o`=1 is ignored: no queuing, no effect on the in-flight multiply.
- `start_i`=0 in IDLE: outputs hold, `done_o`=0.

## Timing
- Reset, taking priority over `start_i`:
  - State IDLE.
  - `result_o`=0, `zero_o`=0, `err_o`=0, `busy_o`=0, `done_o`=0, internal counters and registers 0.
- Reset mid-multiply: abort with no `done_o`; `result_o` reads 0 in the cycle after reset.
- Single-cycle op, with `start_i` high in cycle N:
  - `done_o`=1 and result valid in cycle N+1.
  - `busy_o` stays 0.
  - Back-to-back starts are accepted every cycle.
- Multiply, with `start_i` high in cycle N:
  - `busy_o`=1 in cycles N+1 … N+WIDTH.
  - `done_o`=1 and result valid in cycle N+WIDTH+1, where `busy_o`=0.
  - A new `start_i` in cycle N+WIDTH+1 is accepted.
- `result_o`/`zero_o` keep the previous values during a multiply until its `done_o` cycle.
- `done_o` and `err_o` are never high for more than one consecutive cycle per operation.

## Test plan
- Reset then idle:
  - Hold `rst_i`=1 for 2 cycles, release, no start → all outputs 0 for 5 cycles.
- Single-cycle sweep, 2 -> 3 means `src1_i` -> `src2_i`:
  - add 5+7 → 12, `zero_o`=0.
  - sub 7-7 → 0, `zero_o`=1.
  - slt −1 < 1 → 1.
  - bne-sub 4,4 → 0, `zero_o`=0.
  - jr 0x00400020 → 0x00400020.
  - Each op gives `done_o` exactly 1 cycle after `start_i`.
- Multiply:
  - 0x0000FFFF*0x00010001 → 0xFFFFFFFF.
  - −3*7 → 0xFFFFFFEB.
  - `done_o` 33 cycles after `start_i`; `busy_o` high for exactly 32 cycles.
- Start during busy:
  - Issue add 1+1 at cycle 10 of a multiply → ignored.
  - Only the multiply result appears, one `done_o`.
- Reset mid-multiply:
  - Assert `rst_i` at iteration 15 → no `done_o`, `busy_o`=0 and `result_o`=0 next cycle.
  - A following add 2+3 → 5 after 1 cycle.
- Illegal code 0101 → `result_o`=0, `zero_o`=0, `err_o` and `done_o` pulse together for 1 cycle.
